// File: rtl/pe_pipe_vec.sv
// rtl/pe_pipe_vec.sv - vectorised dual-accumulator MAC processing element with retimed input pipeline
module pe_pipe_vec #(
  parameter int INPUT_W  = 8,
  parameter int OUTPUT_W = 20,
  parameter int C_W      = 32,
  parameter int LANES    = 2,
  parameter int MAC_LAT  = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [LANES*INPUT_W-1:0]    in_a,
  input  logic [LANES*OUTPUT_W-1:0]   in_b,
  input  logic [LANES*OUTPUT_W-1:0]   in_d,
  input  logic                        in_valid,
  input  logic [1:0]                  in_dataflow,
  input  logic                        in_propagate,
  input  logic [4:0]                  in_shift,
  input  logic [2:0]                  in_id,
  input  logic                        in_last,
  output logic [LANES*INPUT_W-1:0]    out_a,
  output logic [LANES*OUTPUT_W-1:0]   out_b,
  output logic [LANES*OUTPUT_W-1:0]   out_c,
  output logic                        out_valid,
  output logic [1:0]                  out_dataflow,
  output logic                        out_propagate,
  output logic [4:0]                  out_shift,
  output logic [2:0]                  out_id,
  output logic                        out_last,
  output logic                        bad_dataflow
);

  typedef struct packed {
    logic [LANES*INPUT_W-1:0]  a;
    logic [LANES*OUTPUT_W-1:0] b;
    logic [LANES*OUTPUT_W-1:0] d;
    logic                      valid;
    logic [1:0]                dataflow;
    logic                      propagate;
    logic [4:0]                shift;
    logic [2:0]                id;
    logic                      last;
  } stage_t;

  localparam logic signed [C_W:0] SAT_MAX = {{(C_W-OUTPUT_W+2){1'b0}}, {(OUTPUT_W-1){1'b1}}};
  localparam logic signed [C_W:0] SAT_MIN = {{(C_W-OUTPUT_W+2){1'b1}}, {(OUTPUT_W-1){1'b0}}};

  stage_t in_s;
  stage_t fin;

  logic signed [C_W-1:0]     c1   [LANES];
  logic signed [C_W-1:0]     c2   [LANES];
  logic signed [C_W-1:0]     c1_n [LANES];
  logic signed [C_W-1:0]     c2_n [LANES];
  logic [LANES*OUTPUT_W-1:0] b_n;
  logic [LANES*OUTPUT_W-1:0] c_n;
  logic                      last_p;
  logic                      os;
  logic [4:0]                s_eff;

  // Round-half-up arithmetic shift, then clamp into the signed OUTPUT_W range.
  function automatic logic [OUTPUT_W-1:0] drain(input logic signed [C_W-1:0] c,
                                                input logic [4:0] s);
    logic signed [C_W:0] t;
    logic signed [C_W:0] rnd;
    t   = (C_W+1)'(c);
    rnd = (s == 5'd0) ? '0 : ((C_W+1)'(1) << (s - 5'd1));
    t   = (t + rnd) >>> s;
    if (t > SAT_MAX)      drain = SAT_MAX[OUTPUT_W-1:0];
    else if (t < SAT_MIN) drain = SAT_MIN[OUTPUT_W-1:0];
    else                  drain = t[OUTPUT_W-1:0];
  endfunction

  assign in_s = '{a: in_a, b: in_b, d: in_d, valid: in_valid, dataflow: in_dataflow,
                  propagate: in_propagate, shift: in_shift, id: in_id, last: in_last};

  generate
    if (MAC_LAT > 1) begin : g_retime
      stage_t sreg [MAC_LAT-1];
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          for (int i = 0; i < MAC_LAT-1; i++) sreg[i] <= '0;
        end else begin
          sreg[0] <= in_s;
          for (int i = 1; i < MAC_LAT-1; i++) sreg[i] <= sreg[i-1];
        end
      end
      assign fin = sreg[MAC_LAT-2];
    end else begin : g_direct
      assign fin = in_s;
    end
  endgenerate

  assign os    = (fin.dataflow == 2'b00);
  assign s_eff = (fin.propagate != last_p) ? fin.shift : 5'd0;

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [INPUT_W-1:0]  a_l;
      logic signed [INPUT_W-1:0]  m2;
      logic signed [OUTPUT_W-1:0] b_l;
      logic signed [OUTPUT_W-1:0] d_l;
      logic signed [C_W-1:0]      own;
      logic signed [C_W-1:0]      other;
      logic signed [C_W-1:0]      prod;
      logic signed [C_W-1:0]      other_n;

      assign a_l   = fin.a[l*INPUT_W +: INPUT_W];
      assign b_l   = fin.b[l*OUTPUT_W +: OUTPUT_W];
      assign d_l   = fin.d[l*OUTPUT_W +: OUTPUT_W];
      // propagate picks which accumulator drains; the other one accumulates (OS) or holds the weight (WS)
      assign own   = fin.propagate ? c1[l] : c2[l];
      assign other = fin.propagate ? c2[l] : c1[l];
      assign m2    = os ? b_l[INPUT_W-1:0] : other[INPUT_W-1:0];
      assign prod  = C_W'(a_l) * C_W'(m2);
      assign other_n = os ? (other + prod) : other;

      assign c_n[l*OUTPUT_W +: OUTPUT_W] = drain(own, os ? s_eff : 5'd0);
      assign b_n[l*OUTPUT_W +: OUTPUT_W] = os ? b_l : (b_l + prod[OUTPUT_W-1:0]);
      assign c1_n[l] = fin.propagate ? C_W'(d_l) : other_n;
      assign c2_n[l] = fin.propagate ? other_n : C_W'(d_l);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int l = 0; l < LANES; l++) begin
        c1[l] <= '0;
        c2[l] <= '0;
      end
      last_p        <= 1'b0;
      out_a         <= '0;
      out_b         <= '0;
      out_c         <= '0;
      out_valid     <= 1'b0;
      out_dataflow  <= '0;
      out_propagate <= 1'b0;
      out_shift     <= '0;
      out_id        <= '0;
      out_last      <= 1'b0;
      bad_dataflow  <= 1'b0;
    end else begin
      out_a         <= fin.a;
      out_valid     <= fin.valid;
      out_dataflow  <= fin.dataflow;
      out_propagate <= fin.propagate;
      out_shift     <= fin.shift;
      out_id        <= fin.id;
      out_last      <= fin.last;
      if (fin.valid) begin
        if (fin.dataflow[1]) begin
          bad_dataflow <= 1'b1;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            c1[l] <= c1_n[l];
            c2[l] <= c2_n[l];
          end
          last_p <= fin.propagate;
          out_b  <= b_n;
          out_c  <= c_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_pipe_vec.sv
// tb/tb_pe_pipe_vec.sv - randomized and directed bench for pe_pipe_vec against an op-level model
module tb_pe_pipe_vec;
  localparam int IW = 8, OW = 20, CW = 32, LN = 2, LAT = 2;

  logic clock = 1'b0;
  logic reset_n;
  logic [LN*IW-1:0] in_a, out_a;
  logic [LN*OW-1:0] in_b, in_d, out_b, out_c;
  logic in_valid, in_propagate, in_last, out_valid, out_propagate, out_last, bad_dataflow;
  logic [1:0] in_dataflow, out_dataflow;
  logic [4:0] in_shift, out_shift;
  logic [2:0] in_id, out_id;

  always #5 clock = ~clock;

  pe_pipe_vec dut (
    .clock(clock), .reset_n(reset_n), .in_a(in_a), .in_b(in_b), .in_d(in_d),
    .in_valid(in_valid), .in_dataflow(in_dataflow), .in_propagate(in_propagate),
    .in_shift(in_shift), .in_id(in_id), .in_last(in_last), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_valid(out_valid), .out_dataflow(out_dataflow),
    .out_propagate(out_propagate), .out_shift(out_shift), .out_id(out_id),
    .out_last(out_last), .bad_dataflow(bad_dataflow)
  );

  typedef struct packed {
    logic [LN*IW-1:0] a;
    logic [LN*OW-1:0] b;
    logic [LN*OW-1:0] c;
    logic valid;
    logic [1:0] df;
    logic prop;
    logic [4:0] sh;
    logic [2:0] id;
    logic last;
    logic bad;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  longint m1[LN], m2s[LN];
  bit m_lp, m_bad;
  logic [LN*OW-1:0] m_ob, m_oc;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sat(input longint v);
    longint hi = (64'sd1 <<< (OW - 1)) - 1;
    longint lo = -(64'sd1 <<< (OW - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint rshift(input longint c, input int s);
    return (s > 0) ? ((c + (64'sd1 <<< (s - 1))) >>> s) : c;
  endfunction

  function automatic logic [LN*IW-1:0] pk_a(input longint l0, input longint l1);
    return {l1[IW-1:0], l0[IW-1:0]};
  endfunction

  function automatic logic [LN*OW-1:0] pk_b(input longint l0, input longint l1);
    return {l1[OW-1:0], l0[OW-1:0]};
  endfunction

  function automatic logic [LN*OW-1:0] rb();
    return (LN*OW)'({$urandom(), $urandom()});
  endfunction

  function automatic logic [LN*IW-1:0] ra();
    return (LN*IW)'($urandom());
  endfunction

  function automatic longint lane_c(input int l);
    logic [OW-1:0] v = out_c[l*OW +: OW];
    return sx(longint'(v), OW);
  endfunction

  function automatic longint lane_b(input int l);
    logic [OW-1:0] v = out_b[l*OW +: OW];
    return sx(longint'(v), OW);
  endfunction

  function automatic void model_clear();
    for (int l = 0; l < LN; l++) begin
      m1[l] = 0;
      m2s[l] = 0;
    end
    m_lp = 0; m_bad = 0; m_ob = '0; m_oc = '0;
  endfunction

  // Drive one input beat, advance the model by one operation and queue the expected outputs.
  task automatic apply(input bit v, input logic [1:0] df, input bit p, input logic [4:0] sh,
                       input logic [LN*IW-1:0] a, input logic [LN*OW-1:0] b,
                       input logic [LN*OW-1:0] d);
    exp_t e;
    int s;
    longint al, bl, dl, own, other, ob, oc;
    in_valid = v; in_dataflow = df; in_propagate = p; in_shift = sh;
    in_a = a; in_b = b; in_d = d;
    in_id = 3'($urandom()); in_last = 1'($urandom());
    if (v) begin
      if (df[1]) begin
        m_bad = 1;
      end else begin
        s = (p != m_lp) ? int'(sh) : 0;
        for (int l = 0; l < LN; l++) begin
          al = sx(longint'(a[l*IW +: IW]), IW);
          bl = sx(longint'(b[l*OW +: OW]), OW);
          dl = sx(longint'(d[l*OW +: OW]), OW);
          own   = p ? m1[l] : m2s[l];
          other = p ? m2s[l] : m1[l];
          if (df == 2'b00) begin
            oc = sat(rshift(own, s));
            ob = bl;
            other = sx(other + al * sx(bl, IW), CW);
          end else begin
            oc = sat(own);
            ob = sx(bl + al * sx(other, IW), OW);
          end
          if (p) begin m1[l] = dl; m2s[l] = other; end
          else   begin m2s[l] = dl; m1[l] = other; end
          m_ob[l*OW +: OW] = ob[OW-1:0];
          m_oc[l*OW +: OW] = oc[OW-1:0];
        end
        m_lp = p;
      end
    end
    e = '{a: a, b: m_ob, c: m_oc, valid: v, df: df, prop: p, sh: sh, id: in_id,
          last: in_last, bad: m_bad};
    q.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    chk("valid", longint'(out_valid), longint'(e.valid));
    chk("sideband", longint'({out_dataflow, out_propagate, out_shift, out_id, out_last}),
        longint'({e.df, e.prop, e.sh, e.id, e.last}));
    chk("out_a", longint'(out_a), longint'(e.a));
    for (int l = 0; l < LN; l++) begin
      chk($sformatf("out_b[%0d]", l), longint'(out_b[l*OW +: OW]), longint'(e.b[l*OW +: OW]));
      chk($sformatf("out_c[%0d]", l), longint'(out_c[l*OW +: OW]), longint'(e.c[l*OW +: OW]));
    end
    chk("bad_dataflow", longint'(bad_dataflow), longint'(e.bad));
  endtask

  task automatic step(input bit v, input logic [1:0] df, input bit p, input logic [4:0] sh,
                      input logic [LN*IW-1:0] a, input logic [LN*OW-1:0] b,
                      input logic [LN*OW-1:0] d);
    @(negedge clock);
    if (q.size() >= LAT) compare(q.pop_front());
    apply(v, df, p, sh, a, b, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 2'($urandom()), 1'($urandom()), 5'($urandom()), ra(), rb(), rb());
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 0; in_valid = 1; in_dataflow = 0; in_propagate = 1'($urandom());
    in_a = ra(); in_b = rb(); in_d = rb();
    repeat (2) @(negedge clock);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_a", longint'(out_a), 0);
    chk("rst_b", longint'(out_b), 0);
    chk("rst_c", longint'(out_c), 0);
    chk("rst_side", longint'({out_dataflow, out_propagate, out_shift, out_id, out_last}), 0);
    chk("rst_bad", longint'(bad_dataflow), 0);
    reset_n = 1;
    q.delete();
    model_clear();
    repeat (LAT - 1) q.push_back(exp_t'('0));
    apply(0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_dataflow = 0; in_propagate = 0; in_shift = 0;
    in_id = 0; in_last = 0; in_a = '0; in_b = '0; in_d = '0;
    do_reset();

    // OS accumulate into c1, then drain it with a flip
    step(1, 0, 0, 0, pk_a(0, 0), rb(), pk_b(0, 0));
    repeat (4) step(1, 0, 0, 0, pk_a(3, 0), pk_b(-4, longint'($urandom())), pk_b(0, 0));
    step(1, 0, 1, 0, pk_a(0, 0), rb(), pk_b(0, 0));
    idle(2);
    chk("os_acc_lane0", lane_c(0), -48);
    chk("os_acc_lane1", lane_c(1), 0);

    // rounding on a shifted drain, then saturation
    step(1, 0, 1, 0, pk_a(-3, 0), pk_b(2, 0), pk_b(0, 0));
    step(1, 0, 0, 2, pk_a(0, 0), rb(), pk_b(0, 0));
    idle(2);
    chk("round_lane0", lane_c(0), -1);
    repeat (40) step(1, 0, 0, 0, pk_a(127, 0), pk_b(127, 0), pk_b(0, 0));
    step(1, 0, 1, 0, pk_a(0, 0), rb(), pk_b(0, 0));
    idle(2);
    chk("sat_lane0", lane_c(0), 524287);

    // weight-stationary: preload c1=5 then use it as the weight
    step(1, 1, 1, 0, pk_a(0, 0), rb(), pk_b(5, 0));
    step(1, 1, 0, 0, pk_a(7, 0), pk_b(100, 0), pk_b(0, 0));
    idle(2);
    chk("ws_b_lane0", lane_b(0), 135);
    chk("ws_c_lane0", lane_c(0), 0);

    // reserved dataflow, then a drain that must see untouched accumulators
    step(1, 2, 1'($urandom()), 5'($urandom()), ra(), rb(), rb());
    idle(2);
    chk("bad_set", longint'(bad_dataflow), 1);
    step(1, 0, 0, 3, ra(), rb(), rb());

    // bubble between drains with a toggled propagate on the idle beat
    step(1, 0, 1, 4, ra(), rb(), rb());
    step(0, 0, 0, 7, ra(), rb(), rb());
    step(1, 0, 1, 5, ra(), rb(), rb());
    idle(1);

    // reset with operations in flight
    repeat (5) step(1, 2'($urandom_range(0, 1)), 1'($urandom()), 5'($urandom()), ra(), rb(), rb());
    do_reset();

    repeat (400)
      step(($urandom() % 5) != 0, 2'($urandom_range(0, 1)), 1'($urandom()), 5'($urandom()),
           ra(), rb(), rb());
    step(1, 3, 1'($urandom()), 5'($urandom()), ra(), rb(), rb());
    repeat (30)
      step(($urandom() % 4) != 0, 2'($urandom_range(0, 1)), 1'($urandom()), 5'($urandom()),
           ra(), rb(), rb());
    idle(LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
